number_signal_stats: RTL

//  Registered, parametrised successor of the combinational sign detector. Classifies each valid

---
 rtl/number_signal_stats.sv | 126 ++++++++++++
 1 files changed

// File: rtl/number_signal_stats.sv
// Registered sign classifier for signed samples: sign, magnitude, sign-change flag and
// saturating per-class (negative / zero / positive) sample counters, one cycle of latency.
module number_signal_stats #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] number,
   output logic             out_valid,
   output logic             num_signal,
   output logic             is_zero,
   output logic [WIDTH-1:0] magnitude,
   output logic             mag_ovf,
   output logic             sign_change,
   output logic [CNT_W-1:0] neg_count,
   output logic [CNT_W-1:0] zero_count,
   output logic [CNT_W-1:0] pos_count
);

   // Class codes double as the history state; counter gi tracks class code gi+1.
   typedef enum logic [1:0] {
      HIST_EMPTY = 2'd0,
      HIST_NEG   = 2'd1,
      HIST_ZERO  = 2'd2,
      HIST_POS   = 2'd3
   } hist_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   hist_t            hist_q, hist_d;
   hist_t            class_s;
   logic             out_valid_q, out_valid_d;
   logic             num_signal_q, num_signal_d;
   logic             is_zero_q, is_zero_d;
   logic [WIDTH-1:0] magnitude_q, magnitude_d;
   logic             mag_ovf_q, mag_ovf_d;
   logic             sign_change_q, sign_change_d;

   always_comb begin
      if (number[WIDTH-1]) begin
         class_s = HIST_NEG;
      end else if (number == '0) begin
         class_s = HIST_ZERO;
      end else begin
         class_s = HIST_POS;
      end
   end

   always_comb begin
      hist_d        = hist_q;
      out_valid_d   = 1'b0;
      num_signal_d  = num_signal_q;
      is_zero_d     = is_zero_q;
      magnitude_d   = magnitude_q;
      mag_ovf_d     = mag_ovf_q;
      sign_change_d = sign_change_q;
      if (clear) begin
         // Sample-shaped outputs keep their value; only history and flags restart.
         hist_d        = HIST_EMPTY;
         sign_change_d = 1'b0;
      end else if (in_valid) begin
         out_valid_d   = 1'b1;
         num_signal_d  = number[WIDTH-1];
         is_zero_d     = (class_s == HIST_ZERO);
         magnitude_d   = number[WIDTH-1] ? (~number + WIDTH'(1)) : number;
         mag_ovf_d     = (number == MOST_NEG);
         sign_change_d = (hist_q != HIST_EMPTY) && (class_s != hist_q);
         hist_d        = class_s;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hist_q        <= HIST_EMPTY;
         out_valid_q   <= 1'b0;
         num_signal_q  <= 1'b0;
         is_zero_q     <= 1'b0;
         magnitude_q   <= '0;
         mag_ovf_q     <= 1'b0;
         sign_change_q <= 1'b0;
      end else begin
         hist_q        <= hist_d;
         out_valid_q   <= out_valid_d;
         num_signal_q  <= num_signal_d;
         is_zero_q     <= is_zero_d;
         magnitude_q   <= magnitude_d;
         mag_ovf_q     <= mag_ovf_d;
         sign_change_q <= sign_change_d;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (clear) begin
            cnt_d = '0;
         end else if (in_valid && (class_s == hist_t'(2'(gi + 1))) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign num_signal  = num_signal_q;
   assign is_zero     = is_zero_q;
   assign magnitude   = magnitude_q;
   assign mag_ovf     = mag_ovf_q;
   assign sign_change = sign_change_q;
   assign neg_count   = g_cnt[0].cnt_q;
   assign zero_count  = g_cnt[1].cnt_q;
   assign pos_count   = g_cnt[2].cnt_q;

endmodule
